// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command front-end.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    ECHO,
    EOL
  } state_t;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  // Byte i selects channel i: 'm' -> 0, 'r' -> 1, 'c' -> 2.
  localparam logic [23:0] DEFAULT_CMD_CHARS = 24'h63_72_6D;

endpackage

// File: rtl/uart_cmd_match.sv
// Combinational ASCII fold plus lowest-index-wins compare against the command table.
module uart_cmd_match #(
  parameter int unsigned          NUM_CMD   = 3,
  parameter logic [8*NUM_CMD-1:0] CMD_CHARS = uart_cmd_pkg::DEFAULT_CMD_CHARS,
  parameter bit                   CASE_FOLD = 1'b1
) (
  input  logic [7:0]         byte_in,
  output logic [NUM_CMD-1:0] match_vec,
  output logic               hit
);

  logic [7:0] folded;

  always_comb begin
    folded = byte_in;
    if (CASE_FOLD && (byte_in >= 8'h41) && (byte_in <= 8'h5A)) begin
      folded = byte_in | 8'h20;
    end
  end

  always_comb begin
    match_vec = '0;
    hit       = 1'b0;
    for (int unsigned i = 0; i < NUM_CMD; i++) begin
      if (!hit && (folded == CMD_CHARS[8*i +: 8])) begin
        match_vec[i] = 1'b1;
        hit          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART/button command front-end: decodes RX bytes into command pulses and echoes to TX.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned          NUM_CMD   = 3,
  parameter logic [8*NUM_CMD-1:0] CMD_CHARS = DEFAULT_CMD_CHARS,
  parameter bit                   CASE_FOLD = 1'b1,
  parameter bit                   ECHO_EN   = 1'b1,
  parameter logic [7:0]           ERR_CHAR  = ASCII_QMARK,
  parameter bit                   EOL_EN    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic [NUM_CMD-1:0] btn_pulse,
  input  logic               tx_full,
  output logic [7:0]         tx_data,
  output logic               tx_push,
  output logic [NUM_CMD-1:0] cmd_pulse,
  output logic               err_pulse,
  output logic               overrun
);

  state_t             state;
  logic [7:0]         work;
  logic [7:0]         hold_data;
  logic               hold_full;
  logic [NUM_CMD-1:0] match_vec;
  logic               match_hit;
  logic               hold_wr;

  uart_cmd_match #(
    .NUM_CMD  (NUM_CMD),
    .CMD_CHARS(CMD_CHARS),
    .CASE_FOLD(CASE_FOLD)
  ) u_match (
    .byte_in  (work),
    .match_vec(match_vec),
    .hit      (match_hit)
  );

  // Push must follow tx_full in the same cycle so a full FIFO is never written.
  assign tx_push = ((state == ECHO) || (state == EOL)) && !tx_full;

  // Any byte not taken straight from IDLE goes through the hold buffer.
  assign hold_wr = rx_valid && ((state != IDLE) || hold_full);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
      tx_data   <= '0;
      cmd_pulse <= '0;
      err_pulse <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      cmd_pulse <= btn_pulse;
      err_pulse <= 1'b0;

      case (state)
        IDLE: begin
          if (hold_full) begin
            work      <= hold_data;
            hold_full <= 1'b0;
            state     <= DECODE;
          end else if (rx_valid) begin
            work  <= rx_data;
            state <= DECODE;
          end
        end
        DECODE: begin
          cmd_pulse <= btn_pulse | match_vec;
          err_pulse <= !match_hit;
          if (ECHO_EN) begin
            tx_data <= match_hit ? work : ERR_CHAR;
            state   <= ECHO;
          end else begin
            state <= IDLE;
          end
        end
        ECHO: begin
          if (!tx_full) begin
            if (EOL_EN) begin
              tx_data <= ASCII_LF;
              state   <= EOL;
            end else begin
              tx_data <= '0;
              state   <= IDLE;
            end
          end
        end
        EOL: begin
          if (!tx_full) begin
            tx_data <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Placed after the FSM so a byte arriving while IDLE consumes the held
      // byte refills the buffer in the same cycle it is freed.
      if (hold_wr) begin
        if (!hold_full || (state == IDLE)) begin
          hold_data <= rx_data;
          hold_full <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: expected pulses/pushes queued at drive time, checked by a monitor.
module tb_uart_cmd_ctrl;
  import uart_cmd_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] btn_pulse;
  logic       tx_full;
  logic [7:0] tx_data;
  logic       tx_push;
  logic [2:0] cmd_pulse;
  logic       err_pulse;
  logic       overrun;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(
    .NUM_CMD  (3),
    .CMD_CHARS(24'h63726D),
    .CASE_FOLD(1'b1),
    .ECHO_EN  (1'b1),
    .ERR_CHAR (8'h3F),
    .EOL_EN   (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .btn_pulse(btn_pulse),
    .tx_full  (tx_full),
    .tx_data  (tx_data),
    .tx_push  (tx_push),
    .cmd_pulse(cmd_pulse),
    .err_pulse(err_pulse),
    .overrun  (overrun)
  );

  typedef struct {
    int         cyc;
    logic [2:0] val;
  } pulse_exp_t;

  pulse_exp_t cmd_q[$];
  int         err_q[$];
  logic [7:0] tx_q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  pulse_exp_t pe;
  logic [7:0] te;
  int         ee;

  // Monitor: every push / pulse the DUT produces must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_push) begin
        n_cmp++;
        if (tx_q.size() == 0) begin
          n_fail++;
          $display("FAIL tx_unexpected: got push data=%h, required no push", tx_data);
        end else begin
          te = tx_q.pop_front();
          if (tx_data !== te) begin
            n_fail++;
            $display("FAIL tx_data: got %h, required %h (cyc %0d)", tx_data, te, cyc);
          end
        end
      end
      if (cmd_pulse !== 3'b000) begin
        n_cmp++;
        if (cmd_q.size() == 0) begin
          n_fail++;
          $display("FAIL cmd_unexpected: got %b at cyc %0d, required 000", cmd_pulse, cyc);
        end else begin
          pe = cmd_q.pop_front();
          if ((cmd_pulse !== pe.val) || (cyc != pe.cyc)) begin
            n_fail++;
            $display("FAIL cmd_pulse: got %b at cyc %0d, required %b at cyc %0d",
                     cmd_pulse, cyc, pe.val, pe.cyc);
          end
        end
      end
      if (err_pulse !== 1'b0) begin
        n_cmp++;
        if (err_q.size() == 0) begin
          n_fail++;
          $display("FAIL err_unexpected: got %b at cyc %0d, required 0", err_pulse, cyc);
        end else begin
          ee = err_q.pop_front();
          if (cyc != ee) begin
            n_fail++;
            $display("FAIL err_cycle: got pulse at cyc %0d, required cyc %0d", cyc, ee);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (tx_q.size() + cmd_q.size() + err_q.size()) != 0; i++)
      @(negedge clk);
    n_cmp++;
    if ((tx_q.size() + cmd_q.size() + err_q.size()) != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: pending tx=%0d cmd=%0d err=%0d, required 0/0/0",
               tx_q.size(), cmd_q.size(), err_q.size());
      tx_q.delete();
      cmd_q.delete();
      err_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_data = '0; rx_valid = 1'b0; btn_pulse = '0; tx_full = 1'b0;
    repeat (3) step();
    @(negedge clk);
    n_cmp++;
    if ({cmd_pulse, err_pulse, tx_push, tx_data, overrun} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got cmd=%b err=%b push=%b data=%h ovr=%b, required all 0",
               cmd_pulse, err_pulse, tx_push, tx_data, overrun);
    end
    step();
    rst = 1'b0;
  endtask

  // One received byte with a free TX FIFO; exp_cmd==0 means an unknown byte.
  task automatic test_decode(input logic [7:0] b, input logic [2:0] exp_cmd,
                             input logic [7:0] exp_echo);
    int t0;
    step();
    rx_data = b; rx_valid = 1'b1; t0 = cyc;
    if (exp_cmd != 3'b000) cmd_q.push_back('{t0 + 2, exp_cmd});
    else err_q.push_back(t0 + 2);
    tx_q.push_back(exp_echo);
    tx_q.push_back(ASCII_LF);
    step();
    rx_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cmd_pulse, err_pulse} !== 4'b0) begin
      n_fail++;
      $display("FAIL decode_early(%h): got cmd=%b err=%b at t+1, required 0", b, cmd_pulse, err_pulse);
    end
    @(negedge clk);
    n_cmp++;
    if (cmd_pulse !== exp_cmd || err_pulse !== (exp_cmd == 3'b000) ||
        tx_push !== 1'b1 || tx_data !== exp_echo) begin
      n_fail++;
      $display("FAIL decode_t2(%h): got cmd=%b err=%b push=%b data=%h, required cmd=%b err=%b push=1 data=%h",
               b, cmd_pulse, err_pulse, tx_push, tx_data, exp_cmd, exp_cmd == 3'b000, exp_echo);
    end
    @(negedge clk);
    n_cmp++;
    if (cmd_pulse !== 3'b000 || err_pulse !== 1'b0 || tx_push !== 1'b1 || tx_data !== ASCII_LF) begin
      n_fail++;
      $display("FAIL decode_t3(%h): got cmd=%b err=%b push=%b data=%h, required cmd=000 err=0 push=1 data=0a",
               b, cmd_pulse, err_pulse, tx_push, tx_data);
    end
    drain(20);
  endtask

  task automatic test_stall_overrun();
    int t0;
    int r;
    step();
    tx_full = 1'b1; rx_data = 8'h6D; rx_valid = 1'b1; t0 = cyc;
    cmd_q.push_back('{t0 + 2, 3'b001});
    tx_q.push_back(8'h6D); tx_q.push_back(ASCII_LF);
    tx_q.push_back(8'h72); tx_q.push_back(ASCII_LF);
    step(); rx_valid = 1'b0;
    step(); rx_data = 8'h72; rx_valid = 1'b1;
    step(); rx_valid = 1'b0;
    step(); rx_data = 8'h63; rx_valid = 1'b1;
    step(); rx_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got %b, required 1", overrun);
    end
    while (cyc < t0 + 10) begin
      @(negedge clk);
      n_cmp++;
      if (tx_push !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_push: got %b at cyc %0d, required 0", tx_push, cyc);
      end
      step();
    end
    tx_full = 1'b0; r = cyc;
    cmd_q.push_back('{r + 4, 3'b010});
    @(negedge clk);
    n_cmp++;
    if (tx_push !== 1'b1 || tx_data !== 8'h6D) begin
      n_fail++;
      $display("FAIL stall_release: got push=%b data=%h, required push=1 data=6d", tx_push, tx_data);
    end
    drain(30);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: got %b, required 1", overrun);
    end
  endtask

  task automatic test_merge(input logic [7:0] b, input logic [2:0] btn, input logic [2:0] exp_cmd);
    int t0;
    step();
    rx_data = b; rx_valid = 1'b1; t0 = cyc;
    cmd_q.push_back('{t0 + 2, exp_cmd});
    tx_q.push_back(b); tx_q.push_back(ASCII_LF);
    step();
    rx_valid = 1'b0; btn_pulse = btn;
    step();
    btn_pulse = '0;
    @(negedge clk);
    n_cmp++;
    if (cmd_pulse !== exp_cmd) begin
      n_fail++;
      $display("FAIL merge(%h,%b): got %b, required %b", b, btn, cmd_pulse, exp_cmd);
    end
    @(negedge clk);
    n_cmp++;
    if (cmd_pulse !== 3'b000) begin
      n_fail++;
      $display("FAIL merge_width(%h): got %b one cycle later, required 000", b, cmd_pulse);
    end
    drain(20);
  endtask

  task automatic test_button(input logic [2:0] btn);
    step();
    btn_pulse = btn;
    cmd_q.push_back('{cyc + 1, btn});
    step();
    btn_pulse = '0;
    @(negedge clk);
    n_cmp++;
    if (cmd_pulse !== btn || tx_push !== 1'b0) begin
      n_fail++;
      $display("FAIL button(%b): got cmd=%b push=%b, required cmd=%b push=0", btn, cmd_pulse, tx_push, btn);
    end
    drain(10);
  endtask

  task automatic test_reset_mid_echo();
    int t0;
    step();
    tx_full = 1'b1; rx_data = 8'h78; rx_valid = 1'b1; t0 = cyc;
    err_q.push_back(t0 + 2);
    step(); rx_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0; tx_full = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({cmd_pulse, err_pulse, tx_push, tx_data, overrun} !== 14'h0 || dut.state !== IDLE) begin
        n_fail++;
        $display("FAIL reset_mid: got cmd=%b err=%b push=%b data=%h ovr=%b state=%0d, required all 0, IDLE",
                 cmd_pulse, err_pulse, tx_push, tx_data, overrun, dut.state);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode(8'h72, 3'b010, 8'h72);
    test_decode(8'h43, 3'b100, 8'h43);
    test_decode(8'h78, 3'b000, 8'h3F);
    test_stall_overrun();
    test_merge(8'h72, 3'b010, 3'b010);
    test_merge(8'h63, 3'b001, 3'b101);
    test_button(3'b100);
    test_reset_mid_echo();
    n_cmp++;
    if ((tx_q.size() + cmd_q.size() + err_q.size()) != 0) begin
      n_fail++;
      $display("FAIL final_queues: got %0d pending, required 0",
               tx_q.size() + cmd_q.size() + err_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Parametrised command front-end between the UART receiver/TX FIFO and the stopwatch/display control logic.
- Decodes received ASCII bytes into one-cycle command pulses, one per command channel.
- Merges these pulses with debounced button pulses, so the board buttons and the UART drive the same controls.
- Optionally echoes each received byte, or an error character, back through the TX FIFO, with a one-byte receive holding buffer and overrun detection.

Parameters:
- NUM_CMD, 3, number of command channels (1..8).
- CMD_CHARS, {"m","r","c"}, packed 8*NUM_CMD bits; byte i is the ASCII code for channel i (index 0 = LSB byte).
- CASE_FOLD, 1, when 1, fold 'A'..'Z' to lowercase before compare; CMD_CHARS are given in lowercase.
- ECHO_EN, 1, when 1, echo each decoded byte to TX.
- ERR_CHAR, 8'h3F, byte echoed in place of an unknown byte ('?').
- EOL_EN, 1, when 1 and ECHO_EN=1, push 8'h0A after each echo.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx_data  in  8  received byte, valid while rx_valid=1
- rx_valid  in  1  one-cycle strobe from UART RX (rx_done)
- btn_pulse  in  NUM_CMD  one-cycle debounced button pulses, per channel
- tx_full  in  1  TX FIFO full
- tx_data  out  8  byte to TX FIFO
- tx_push  out  1  TX FIFO write strobe
- cmd_pulse  out  NUM_CMD  registered one-cycle command pulses
- err_pulse  out  1  one-cycle pulse on an unknown byte
- overrun  out  1  sticky; a byte was dropped

Behaviour:
- Reset:
  - All outputs 0; state IDLE; hold buffer empty; overrun cleared.
  - Reset mid-operation aborts any pending echo or EOL; no partial push afterwards.
- FSM states: IDLE, DECODE, ECHO, EOL.
- IDLE:
  - If the hold buffer is full, load the held byte into the work register, clear the hold buffer, go to DECODE.
  - Otherwise, if rx_valid=1, load rx_data into the work register, go to DECODE.
  - Otherwise stay in IDLE.
- DECODE (exactly one cycle):
  - Compare the folded work byte against every CMD_CHARS entry.
  - Match: set bit i of the cmd_pulse next-value, for the lowest matching index i only.
  - No match: set the err_pulse next-value.
  - Next state: ECHO if ECHO_EN=1, else IDLE.
- ECHO:
  - tx_push = !tx_full.
  - tx_data = work byte if it matched, else ERR_CHAR.
  - On push, go to EOL if EOL_EN=1, else IDLE.
  - While tx_full=1, stay in ECHO with tx_push=0.
- EOL: same push rule with tx_data=8'h0A; on push go to IDLE.
- tx_data is held stable while tx_push=0 in ECHO/EOL; it is 0 otherwise.
- Latency:
  - UART path: rx_valid in cycle t; DECODE in t+1; cmd_pulse/err_pulse high in t+2 for exactly one cycle.
  - Button path: btn_pulse in cycle n -> cmd_pulse in cycle n+1.
- Merge: cmd_pulse = registered (btn_pulse | uart_match).
  - A button and a UART hit in the same cycle on the same channel give one pulse.
  - Hits on different channels in the same cycle give both bits high.
- Holding buffer:
  - rx_valid outside IDLE, or while IDLE is consuming the held byte, writes the hold buffer if it is empty.
  - If the hold buffer is full, the byte is dropped and overrun is set; overrun is cleared only by rst.
- The held byte has priority over a simultaneous new rx_valid.
- CASE_FOLD: fold applies to the compare only; echo returns the original byte.
- Duplicate CMD_CHARS entries: the lowest index wins.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - the state typedef (IDLE, DECODE, ECHO, EOL);
  - constants ASCII_LF=8'h0A and ASCII_QMARK=8'h3F;
  - the default CMD_CHARS.
- One sub-module, uart_cmd_match: a combinational fold plus priority compare, producing a one-hot match vector and a hit flag.

Test Plan:
- Reset, then rx 'r' (8'h72) with tx_full=0 -> cmd_pulse=3'b010 at t+2 for 1 cycle; tx pushes 8'h72 then 8'h0A; err_pulse=0.
- rx 'C' (8'h43), CASE_FOLD=1 -> cmd_pulse=3'b100; echo pushes 8'h43, not 8'h63.
- rx 'x' (8'h78) -> cmd_pulse=0; err_pulse one cycle at t+2; tx pushes 8'h3F then 8'h0A.
- tx_full=1 for 10 cycles after rx 'm' -> cmd_pulse=3'b001 at t+2; tx_push=0 while tx_full=1; 8'h6D pushed in the first cycle after tx_full=0.
  - During the stall, rx 'r' goes to the hold buffer; a third byte 'c' sets overrun=1.
  - After the stall, 'r' is decoded, 'c' never produces a pulse, and overrun stays 1 until rst.
- btn_pulse=3'b010 in the same cycle that DECODE matches 'r' -> a single cmd_pulse=3'b010.
  - btn_pulse=3'b001 concurrent with a UART 'c' hit -> cmd_pulse=3'b101.
- rst asserted in ECHO while tx_full=1 -> after reset, no pushes, all outputs 0, overrun 0, state IDLE.
